// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch PC unit
package fetch_pkg;

    localparam int          ADDR_WIDTH   = 32;
    localparam int          INSTR_BYTES  = 4;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    // One in-flight fetch: was it on the committed path, where it came from,
    // and where the BHT said the stream would go next.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pred_next;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - cache/BHT/EX signal bundle around the fetch PC unit
interface fetch_pc_unit_if #(
    parameter int ADDR_WIDTH = 32
);

    logic                  CACHE_READY;
    logic                  CACHE_READY_DATA;
    logic                  PRD_VALID;
    logic [ADDR_WIDTH-1:0] PRD_ADDR;
    logic                  EX_BRANCH;
    logic                  EX_BRANCH_TAKEN;
    logic [ADDR_WIDTH-1:0] EX_BRANCH_ADDR;

    logic [ADDR_WIDTH-1:0] PC;
    logic [ADDR_WIDTH-1:0] EX_PC;
    logic                  EX_VALID;
    logic                  PREDICTED;
    logic                  FLUSH;
    logic [31:0]           BRANCH_CNT;
    logic [31:0]           MISPRED_CNT;

    modport master (
        output CACHE_READY, CACHE_READY_DATA, PRD_VALID, PRD_ADDR,
        output EX_BRANCH, EX_BRANCH_TAKEN, EX_BRANCH_ADDR,
        input  PC, EX_PC, EX_VALID, PREDICTED, FLUSH, BRANCH_CNT, MISPRED_CNT
    );

    modport slave (
        input  CACHE_READY, CACHE_READY_DATA, PRD_VALID, PRD_ADDR,
        input  EX_BRANCH, EX_BRANCH_TAKEN, EX_BRANCH_ADDR,
        output PC, EX_PC, EX_VALID, PREDICTED, FLUSH, BRANCH_CNT, MISPRED_CNT
    );

endinterface

// File: rtl/fetch_slot_pipe.sv
// rtl/fetch_slot_pipe.sv - IF..EX shift register of fetch slots with squash
module fetch_slot_pipe #(
    parameter int NUM_STAGES = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   adv,
    input  logic                   squash,
    input  fetch_pkg::fetch_slot_t in_slot,
    output fetch_pkg::fetch_slot_t ex_slot
);

    import fetch_pkg::*;

    fetch_slot_t stage_q [NUM_STAGES];
    fetch_slot_t stage_d [NUM_STAGES];

    // A squash kills everything that shifts in this cycle, so every new
    // valid bit is forced low, including the slot landing in EX.
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_d[i] = stage_q[i];
        end
        stage_d[0]       = in_slot;
        stage_d[0].valid = in_slot.valid & ~squash;
        for (int i = 1; i < NUM_STAGES; i++) begin
            stage_d[i]       = stage_q[i-1];
            stage_d[i].valid = stage_q[i-1].valid & ~squash;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else if (adv) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign ex_slot = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC register, prediction tracking and EX resolve
module fetch_pc_unit #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    NUM_STAGES   = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic            CLK,
    input  logic            RST,
    fetch_pc_unit_if.slave  bus
);

    import fetch_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_BYTES);

    logic                  adv;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  flush_q;
    logic [31:0]           branch_cnt_q;
    logic [31:0]           mispred_cnt_q;

    logic [ADDR_WIDTH-1:0] next_pred;
    logic [ADDR_WIDTH-1:0] actual_next;
    logic                  ex_taken;
    logic                  mispred;
    fetch_slot_t           in_slot;
    fetch_slot_t           ex_slot;

    assign adv = bus.CACHE_READY & bus.CACHE_READY_DATA;

    // Non-branches always resolve to pc+4, which also catches a BHT entry
    // aliasing onto a straight-line instruction and predicting it taken.
    always_comb begin
        next_pred   = bus.PRD_VALID ? bus.PRD_ADDR : pc_q + STEP;
        ex_taken    = bus.EX_BRANCH & bus.EX_BRANCH_TAKEN;
        actual_next = ex_taken ? bus.EX_BRANCH_ADDR : ex_slot.pc + STEP;
        mispred     = ex_slot.valid & (ex_slot.pred_next != actual_next);
    end

    always_comb begin
        in_slot           = '0;
        in_slot.valid     = 1'b1;
        in_slot.pc        = pc_q;
        in_slot.pred_next = next_pred;
    end

    fetch_slot_pipe #(
        .NUM_STAGES (NUM_STAGES)
    ) u_slot_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .adv     (adv),
        .squash  (mispred),
        .in_slot (in_slot),
        .ex_slot (ex_slot)
    );

    // Everything, FLUSH included, freezes while the caches stall; a pending
    // redirect is taken on the first advancing cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q          <= RESET_VECTOR;
            flush_q       <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (adv) begin
            pc_q    <= mispred ? actual_next : next_pred;
            flush_q <= mispred;
            if (ex_slot.valid & bus.EX_BRANCH) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispred) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign bus.PC          = pc_q;
    assign bus.EX_PC       = ex_slot.pc;
    assign bus.EX_VALID    = ex_slot.valid;
    assign bus.PREDICTED   = ~mispred;
    assign bus.FLUSH       = flush_q;
    assign bus.BRANCH_CNT  = branch_cnt_q;
    assign bus.MISPRED_CNT = mispred_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    fetch_pc_unit_if #(.ADDR_WIDTH(32)) bus ();

    fetch_pc_unit #(
        .ADDR_WIDTH   (32),
        .NUM_STAGES   (3),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ex_pc;
        logic        ex_valid;
        logic        flush;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t sb[$];

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] m_pc;
    logic        m_v [3];
    logic [31:0] m_p [3];
    logic [31:0] m_n [3];
    logic        m_flush;
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_flush = 1'b0; m_bc = 32'h0; m_mc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0; m_p[i] = 32'h0; m_n[i] = 32'h0;
        end
    endtask

    task automatic step(input logic rst, input logic rdy, input logic rdyd,
                        input logic pv, input logic [31:0] pa,
                        input logic br, input logic tk, input logic [31:0] ba);
        logic [31:0] act, npred;
        logic        mis;
        exp_t        e;
        RST = rst;
        bus.CACHE_READY = rdy; bus.CACHE_READY_DATA = rdyd;
        bus.PRD_VALID = pv; bus.PRD_ADDR = pa;
        bus.EX_BRANCH = br; bus.EX_BRANCH_TAKEN = tk; bus.EX_BRANCH_ADDR = ba;
        #1;
        act = (br && tk) ? ba : m_p[2] + 32'd4;
        mis = m_v[2] && (m_n[2] != act);
        chk("predicted", {31'b0, bus.PREDICTED}, {31'b0, ~mis});
        if (rst) begin
            model_reset();
        end else if (rdy && rdyd) begin
            npred = pv ? pa : m_pc + 32'd4;
            if (m_v[2] && br) m_bc = m_bc + 32'd1;
            if (mis) m_mc = m_mc + 32'd1;
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1] && !mis; m_p[i] = m_p[i-1]; m_n[i] = m_n[i-1];
            end
            m_v[0] = !mis; m_p[0] = m_pc; m_n[0] = npred;
            m_pc = mis ? act : npred;
            m_flush = mis;
        end
        e.pc = m_pc; e.ex_pc = m_p[2]; e.ex_valid = m_v[2];
        e.flush = m_flush; e.bcnt = m_bc; e.mcnt = m_mc;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("pc", bus.PC, e.pc);
            chk("ex_pc", bus.EX_PC, e.ex_pc);
            chk("ex_valid", {31'b0, bus.EX_VALID}, {31'b0, e.ex_valid});
            chk("flush", {31'b0, bus.FLUSH}, {31'b0, e.flush});
            chk("branch_cnt", bus.BRANCH_CNT, e.bcnt);
            chk("mispred_cnt", bus.MISPRED_CNT, e.mcnt);
        end
    endtask

    // Shorthand: advancing step, BHT says pc+4, EX is not a branch.
    task automatic adv_plain();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        bus.CACHE_READY = 1'b0; bus.CACHE_READY_DATA = 1'b0;
        bus.PRD_VALID = 1'b0; bus.PRD_ADDR = 32'h0;
        bus.EX_BRANCH = 1'b0; bus.EX_BRANCH_TAKEN = 1'b0; bus.EX_BRANCH_ADDR = 32'h0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        chk("rst_pc", bus.PC, 32'h0);
        chk("rst_ex_valid", {31'b0, bus.EX_VALID}, 32'd0);
        chk("rst_ex_pc", bus.EX_PC, 32'h0);
        chk("rst_predicted", {31'b0, bus.PREDICTED}, 32'd1);
        chk("rst_flush", {31'b0, bus.FLUSH}, 32'd0);
        chk("rst_bcnt", bus.BRANCH_CNT, 32'd0);
        chk("rst_mcnt", bus.MISPRED_CNT, 32'd0);

        // Sequential fetch fills the pipe.
        adv_plain(); chk("seq_pc1", bus.PC, 32'h4);
        adv_plain(); chk("seq_pc2", bus.PC, 32'h8);
        adv_plain(); chk("seq_pc3", bus.PC, 32'hC);
        chk("seq_ex_valid", {31'b0, bus.EX_VALID}, 32'd1);
        chk("seq_ex_pc", bus.EX_PC, 32'h0);
        chk("seq_flush", {31'b0, bus.FLUSH}, 32'd0);

        // Predicted taken, resolved taken.
        adv_plain();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        chk("pt_pc", bus.PC, 32'h100);
        adv_plain(); adv_plain();
        chk("pt_ex_pc", bus.EX_PC, 32'h10);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
        chk("pt_bcnt", bus.BRANCH_CNT, 32'd1);
        chk("pt_mcnt", bus.MISPRED_CNT, 32'd0);
        chk("pt_flush", {31'b0, bus.FLUSH}, 32'd0);

        // Predicted not-taken, resolved taken to 0x200 at EX_PC=0x20.
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
        adv_plain(); adv_plain();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20);
        chk("nt_ex_pc", bus.EX_PC, 32'h20);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
        chk("nt_pc", bus.PC, 32'h200);
        chk("nt_flush", {31'b0, bus.FLUSH}, 32'd1);
        chk("nt_mcnt", bus.MISPRED_CNT, 32'd1);
        adv_plain();
        chk("nt_flush_drop", {31'b0, bus.FLUSH}, 32'd0);
        chk("nt_squash1", {31'b0, bus.EX_VALID}, 32'd0);
        adv_plain();
        chk("nt_squash2", {31'b0, bus.EX_VALID}, 32'd0);
        adv_plain();
        chk("nt_refill", {31'b0, bus.EX_VALID}, 32'd1);
        chk("nt_refill_pc", bus.EX_PC, 32'h200);

        // Non-branch at 0x40 predicted taken to 0x300, mispredict met by a stall.
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        adv_plain();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
        chk("alias_ex_pc", bus.EX_PC, 32'h40);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        end
        chk("stall_pc", bus.PC, 32'h308);
        chk("stall_flush", {31'b0, bus.FLUSH}, 32'd0);
        chk("stall_mcnt", bus.MISPRED_CNT, 32'd1);
        chk("stall_predicted", {31'b0, bus.PREDICTED}, 32'd0);
        adv_plain();
        chk("alias_pc", bus.PC, 32'h44);
        chk("alias_flush", {31'b0, bus.FLUSH}, 32'd1);
        chk("alias_mcnt", bus.MISPRED_CNT, 32'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("flush_held", {31'b0, bus.FLUSH}, 32'd1);
        adv_plain();
        chk("flush_clear", {31'b0, bus.FLUSH}, 32'd0);

        // Reset on the same cycle as an advancing mispredict.
        adv_plain(); adv_plain();
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h500);
        chk("rr_pc", bus.PC, 32'h0);
        chk("rr_flush", {31'b0, bus.FLUSH}, 32'd0);
        chk("rr_bcnt", bus.BRANCH_CNT, 32'd0);
        chk("rr_mcnt", bus.MISPRED_CNT, 32'd0);
        chk("rr_ex_valid", {31'b0, bus.EX_VALID}, 32'd0);

        // Address wrap and low-bit passthrough.
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        adv_plain();
        chk("wrap_pc", bus.PC, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h1002, 1'b0, 1'b0, 32'h0);
        chk("lowbits_pc", bus.PC, 32'h1002);
        adv_plain();
        chk("wrap_resolve_pc", bus.PC, 32'h4);
        chk("wrap_resolve_mcnt", bus.MISPRED_CNT, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Owns the fetch program counter, the PC fed to the instruction cache and to the branch history table lookup.
- Advances PC to the BHT's predicted next address every time the cache pipeline advances.
- Carries each fetched PC and its predicted successor down a shift pipeline aligned with the IF/ID/EX stages.
- In EX, compares the prediction with the resolved outcome and produces the PREDICTED / FLUSH / EX_PC / branch-resolution signals consumed by the BHT and the pipeline.

Parameters:
- ADDR_WIDTH, 32, width of PC and all addresses.
- NUM_STAGES, 3, fetch-to-execute depth; stage NUM_STAGES-1 is EX. Legal range ≥2.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
- CACHE_READY  input  1  instruction cache can accept a new fetch.
- CACHE_READY_DATA  input  1  data cache not stalling; advance = CACHE_READY & CACHE_READY_DATA.
- PRD_VALID  input  1  BHT prediction usable; when 0, next PC is PC+4.
- PRD_ADDR  input  ADDR_WIDTH  BHT predicted next PC for current PC.
- EX_BRANCH  input  1  instruction in EX is a conditional branch or jump.
- EX_BRANCH_TAKEN  input  1  EX control transfer resolved taken.
- EX_BRANCH_ADDR  input  ADDR_WIDTH  resolved target of EX control transfer.
- PC  output  ADDR_WIDTH  current fetch PC (registered).
- EX_PC  output  ADDR_WIDTH  PC of the instruction in EX.
- EX_VALID  output  1  EX slot holds a non-squashed instruction.
- PREDICTED  output  1  0 when the EX instruction was mispredicted (combinational).
- FLUSH  output  1  registered one-cycle pulse following a redirect.
- BRANCH_CNT  output  32  count of valid EX branches retired on advance.
- MISPRED_CNT  output  32  count of mispredictions acted on.

Behaviour:
- Reset, synchronous, overrides everything: PC=RESET_VECTOR, all stage valids=0, stage pc/pred=0, FLUSH=0, counters=0. Consequently EX_VALID=0, PREDICTED=1, EX_PC=0.
- adv = CACHE_READY & CACHE_READY_DATA. When adv=0, every register holds, including FLUSH.
- Each stage record holds {valid, pc, pred_next}; stage 0 is the youngest.
- On adv: stage[0] <= {1, PC, next_pred}, where next_pred = PRD_VALID ? PRD_ADDR : PC+4. Stage[i] <= stage[i-1] for i ≥ 1.
- EX = stage[NUM_STAGES-1]: EX_PC = EX.pc, EX_VALID = EX.valid.
- actual_next = (EX_BRANCH & EX_BRANCH_TAKEN) ? EX_BRANCH_ADDR : EX.pc+4. Non-branches therefore always resolve to pc+4, which also catches aliasing false-taken predictions.
- mispred = EX.valid & (EX.pred_next != actual_next); PREDICTED = ~mispred.
- On adv & mispred:
  - PC <= actual_next; the BHT output is ignored this cycle.
  - All stages younger than EX are cleared, so the newly shifted stage[1..N-1] valids are 0.
  - stage[0] receives {0, PC, next_pred}: the wrong-path fetch is squashed.
  - FLUSH <= 1 for exactly one advancing cycle.
  - MISPRED_CNT increments.
- On adv & ~mispred: PC <= next_pred; FLUSH <= 0.
- BRANCH_CNT increments on adv & EX.valid & EX_BRANCH.
- Counters wrap modulo 2^32.
- Address arithmetic: +4 is modulo 2^ADDR_WIDTH, so PC wraps from 32'hFFFF_FFFC to 0. PC[1:0] is passed through unmodified.
- Mispredict during a stall is not acted on until the first adv cycle. Inputs must be held stable by the producers across the stall.
- Back-to-back mispredicts are impossible: after a redirect, EX valid is 0 for NUM_STAGES-1 advances.
- Reset asserted mid-redirect wins; FLUSH is 0 on the cycle after reset.

Decomposition:
- Shared package fetch_pkg holds:
  - struct fetch_slot_t {valid, pc, pred_next};
  - constants RESET_VECTOR and INSTR_BYTES=4;
  - the ADDR_WIDTH default.
- One sub-module, fetch_slot_pipe: a NUM_STAGES-deep shift register of fetch_slot_t with enable (adv) and squash (clear valids of stages <NUM_STAGES-1) inputs, outputting the EX slot.
- Compare logic, PC register and counters stay in fetch_pc_unit.

Test Plan:
- Reset, then adv=1 for 3 cycles with PRD_VALID=0 → PC = 0x0 → 0x4 → 0x8 → 0xC; EX_VALID=1 and EX_PC=0x0 on the cycle after the third advance; PREDICTED=1; FLUSH=0.
- Predicted taken, resolved taken: PRD_ADDR=0x100 while PC=0x10; EX_BRANCH=1, TAKEN=1, ADDR=0x100 when EX_PC=0x10 → PREDICTED=1, no flush, BRANCH_CNT=1, MISPRED_CNT=0.
- Predicted not-taken, resolved taken to 0x200 at EX_PC=0x20 → PREDICTED=0; next PC=0x200; FLUSH=1 for one cycle; EX_VALID=0 for the next 2 advances; MISPRED_CNT=1.
- Predicted taken to 0x300 for a non-branch at PC=0x40 → mispredict in EX; PC redirected to 0x44; FLUSH pulse.
- Mispredict present while CACHE_READY_DATA=0 for 4 cycles → PC, FLUSH and counters frozen; redirect occurs on the first cycle CACHE_READY_DATA=1.
- RST asserted on the same cycle as an adv mispredict → next cycle PC=RESET_VECTOR, FLUSH=0, counters=0, EX_VALID=0.
